// File: rtl/audio_tone_mixer.sv
// audio_tone_mixer
//   Multi-voice square-wave tone generator mixed into the codec ADC->DAC path.
//   Each voice toggles its phase every (period+1) cycles and contributes +/-amp.
//   The contributions are summed with the latched ADC sample at SAMPLE_W+4 bits,
//   then saturated to SAMPLE_W bits. The FIFO handshake is sequenced by a
//   four-state FSM: IDLE -> POP -> MIX -> WRITE.
//   Optional feature macro: STEREO_PAN_EN. When it is defined, each voice stores
//   a pan mask {left_en,right_en} that selects which channel sums include it.
//   When it is not defined, every voice feeds both channels and no pan storage
//   is built.
module audio_tone_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 32,
  parameter int DIV_W      = 19,
  parameter int AMP_W      = 24
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [2:0]          cfg_voice,
  input  logic [DIV_W-1:0]    cfg_period,
  input  logic [AMP_W-1:0]    cfg_amp,
  input  logic [1:0]          cfg_pan,
  input  logic                mute,
  input  logic                audio_in_available,
  input  logic                audio_out_allowed,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic [SAMPLE_W-1:0] right_channel_audio_in,
  output logic                read_audio_in,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out
);

  localparam int ACC_W = SAMPLE_W + 4;

  // Clamp limits expressed at the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{5{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{5{1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_MIX   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Saturate an accumulator value to the signed sample range.
  function automatic logic [SAMPLE_W-1:0] sat_f(input logic signed [ACC_W-1:0] x);
    logic [SAMPLE_W-1:0] r;
    if (x > SAT_MAX) begin
      r = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (x < SAT_MIN) begin
      r = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

  // Voice state
  logic [DIV_W-1:0]      period_q [NUM_VOICES];
  logic [DIV_W-1:0]      cnt_q    [NUM_VOICES];
  logic [AMP_W-1:0]      amp_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0] phase_q;
`ifdef STEREO_PAN_EN
  logic [1:0]            pan_q    [NUM_VOICES];
`else
  logic                  pan_unused_d;
  assign pan_unused_d = ^cfg_pan;
`endif

  // Datapath / FSM state
  state_t                state_q;
  logic                  read_q;
  logic [SAMPLE_W-1:0]   in_l_q;
  logic [SAMPLE_W-1:0]   in_r_q;
  logic [SAMPLE_W-1:0]   out_l_q;
  logic [SAMPLE_W-1:0]   out_r_q;

  logic signed [ACC_W-1:0] contrib_d [NUM_VOICES];
  logic signed [ACC_W-1:0] left_sum_d;
  logic signed [ACC_W-1:0] right_sum_d;

  // Free-running voice counters; a config write reloads a voice and restarts its phase.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        period_q[v] <= {DIV_W{1'b0}};
        cnt_q[v]    <= {DIV_W{1'b0}};
        amp_q[v]    <= {AMP_W{1'b0}};
        phase_q[v]  <= 1'b0;
`ifdef STEREO_PAN_EN
        pan_q[v]    <= 2'b11;
`endif
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_wr && (cfg_voice == 3'(v))) begin
          period_q[v] <= cfg_period;
          amp_q[v]    <= cfg_amp;
          cnt_q[v]    <= {DIV_W{1'b0}};
          phase_q[v]  <= 1'b0;
`ifdef STEREO_PAN_EN
          pan_q[v]    <= cfg_pan;
`endif
        end else if (period_q[v] == {DIV_W{1'b0}}) begin
          cnt_q[v]    <= {DIV_W{1'b0}};
          phase_q[v]  <= 1'b0;
        end else if (cnt_q[v] == period_q[v]) begin
          cnt_q[v]    <= {DIV_W{1'b0}};
          phase_q[v]  <= ~phase_q[v];
        end else begin
          cnt_q[v]    <= cnt_q[v] + DIV_W'(1);
        end
      end
    end
  end

  // Per-voice signed contribution: +amp in phase 1, -amp in phase 0, zero when muted or silent.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!mute && (period_q[v] != {DIV_W{1'b0}})) begin
        if (phase_q[v]) begin
          contrib_d[v] = $signed({{(ACC_W-AMP_W){1'b0}}, amp_q[v]});
        end else begin
          contrib_d[v] = -$signed({{(ACC_W-AMP_W){1'b0}}, amp_q[v]});
        end
      end else begin
        contrib_d[v] = {ACC_W{1'b0}};
      end
    end
  end

  // Channel sums: latched input sample plus the selected voice contributions.
  always_comb begin
    left_sum_d  = $signed({{4{in_l_q[SAMPLE_W-1]}}, in_l_q});
    right_sum_d = $signed({{4{in_r_q[SAMPLE_W-1]}}, in_r_q});
    for (int v = 0; v < NUM_VOICES; v++) begin
`ifdef STEREO_PAN_EN
      left_sum_d  = left_sum_d  + (pan_q[v][1] ? contrib_d[v] : {ACC_W{1'b0}});
      right_sum_d = right_sum_d + (pan_q[v][0] ? contrib_d[v] : {ACC_W{1'b0}});
`else
      left_sum_d  = left_sum_d  + contrib_d[v];
      right_sum_d = right_sum_d + contrib_d[v];
`endif
    end
  end

  // Handshake sequencer: accept, pop pulse, mix into output registers, wait for DAC space.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      read_q  <= 1'b0;
      in_l_q  <= {SAMPLE_W{1'b0}};
      in_r_q  <= {SAMPLE_W{1'b0}};
      out_l_q <= {SAMPLE_W{1'b0}};
      out_r_q <= {SAMPLE_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (audio_in_available && audio_out_allowed) begin
            in_l_q  <= left_channel_audio_in;
            in_r_q  <= right_channel_audio_in;
            read_q  <= 1'b1;
            state_q <= S_POP;
          end else begin
            read_q  <= 1'b0;
          end
        end
        S_POP: begin
          read_q  <= 1'b0;
          state_q <= S_MIX;
        end
        S_MIX: begin
          read_q  <= 1'b0;
          out_l_q <= sat_f(left_sum_d);
          out_r_q <= sat_f(right_sum_d);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          read_q <= 1'b0;
          if (audio_out_allowed) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WRITE;
          end
        end
        default: begin
          read_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign read_audio_in           = read_q;
  assign write_audio_out         = (state_q == S_WRITE) && audio_out_allowed;
  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Directed bench for audio_tone_mixer: a vector table for single-voice mixing
// plus hand-written sequences for saturation, stalls, ignored config and reset.
module tb_audio_tone_mixer;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr;
  logic [2:0]  cfg_voice;
  logic [18:0] cfg_period;
  logic [23:0] cfg_amp;
  logic [1:0]  cfg_pan;
  logic        mute;
  logic        avail;
  logic        allowed;
  logic [31:0] l_in;
  logic [31:0] r_in;
  logic        rd;
  logic        wr;
  logic [31:0] l_out;
  logic [31:0] r_out;

  int n_checks = 0;
  int n_errors = 0;

  audio_tone_mixer dut (
    .CLOCK_50               (clk),
    .reset_n                (rst_n),
    .cfg_wr                 (cfg_wr),
    .cfg_voice              (cfg_voice),
    .cfg_period             (cfg_period),
    .cfg_amp                (cfg_amp),
    .cfg_pan                (cfg_pan),
    .mute                   (mute),
    .audio_in_available     (avail),
    .audio_out_allowed      (allowed),
    .left_channel_audio_in  (l_in),
    .right_channel_audio_in (r_in),
    .read_audio_in          (rd),
    .write_audio_out        (wr),
    .left_channel_audio_out (l_out),
    .right_channel_audio_out(r_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] period;
    logic [23:0] amp;
    logic        mute;
    int          dly;
    logic [31:0] in_l;
    logic [31:0] in_r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the config edge is the next posedge; returns at a negedge.
  task automatic cfg(input logic [2:0] v, input logic [18:0] p, input logic [23:0] a,
                     input logic [1:0] pan);
    cfg_wr = 1'b1; cfg_voice = v; cfg_period = p; cfg_amp = a; cfg_pan = pan;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Full sample-pair transfer with DAC space available throughout.
  task automatic run_txn(input logic [31:0] li, input logic [31:0] ri,
                         input logic [31:0] el, input logic [31:0] er, input string tag);
    l_in = li; r_in = ri; avail = 1'b1; allowed = 1'b1;
    @(negedge clk);                       // POP state
    check({tag, "_read"}, {31'd0, rd}, 32'd1);
    avail = 1'b0;
    @(negedge clk);                       // MIX state
    @(negedge clk);                       // WRITE state
    check({tag, "_write"}, {31'd0, wr}, 32'd1);
    check({tag, "_left"},  l_out, el);
    check({tag, "_right"}, r_out, er);
    @(negedge clk);                       // back in IDLE
    check({tag, "_write_off"}, {31'd0, wr}, 32'd0);
  endtask

  // Read and write pulses must never coincide.
  always @(negedge clk) begin
    if (rst_n && rd && wr) begin
      n_errors++;
      $display("FAIL rd_wr_overlap: rd=%0b wr=%0b expected not both 1", rd, wr);
    end
  end

  initial begin
    logic        ok;
    logic [31:0] exp_r_pan;

    // voice 0 only; phase seen at MIX is that after edge (2+dly) from config
    tbl[0] = '{19'd4,    24'd100, 1'b0, 0,    32'd0,    32'd0,     -32'sd100,  -32'sd100};
    tbl[1] = '{19'd4,    24'd100, 1'b0, 2,    32'd0,    32'd0,     -32'sd100,  -32'sd100};
    tbl[2] = '{19'd4,    24'd100, 1'b0, 3,    32'd0,    32'd0,      32'sd100,   32'sd100};
    tbl[3] = '{19'd4,    24'd100, 1'b0, 7,    32'd0,    32'd0,      32'sd100,   32'sd100};
    tbl[4] = '{19'd4,    24'd100, 1'b0, 8,    32'd0,    32'd0,     -32'sd100,  -32'sd100};
    tbl[5] = '{19'd1000, 24'd100, 1'b0, 1005, 32'd1000, -32'sd1000, 32'sd1100, -32'sd900};
    tbl[6] = '{19'd1000, 24'd100, 1'b0, 0,    32'd1000, -32'sd1000, 32'sd900,  -32'sd1100};
    tbl[7] = '{19'd1000, 24'd100, 1'b1, 1005, 32'd500,  32'd500,    32'sd500,   32'sd500};
    tbl[8] = '{19'd0,    24'd100, 1'b0, 3,    32'd500,  32'd500,    32'sd500,   32'sd500};

    rst_n = 1'b0; cfg_wr = 1'b0; cfg_voice = 3'd0; cfg_period = 19'd0; cfg_amp = 24'd0;
    cfg_pan = 2'b11; mute = 1'b0; avail = 1'b0; allowed = 1'b0; l_in = 32'd0; r_in = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_read",  {31'd0, rd}, 32'd0);
    check("rst_write", {31'd0, wr}, 32'd0);
    check("rst_left",  l_out, 32'd0);
    check("rst_right", r_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: single voice with various periods, phases and mute
    for (int i = 0; i < 9; i++) begin
      cfg(3'd0, tbl[i].period, tbl[i].amp, 2'b11);
      mute = tbl[i].mute;
      repeat (tbl[i].dly) @(negedge clk);
      run_txn(tbl[i].in_l, tbl[i].in_r, tbl[i].exp_l, tbl[i].exp_r, $sformatf("vec%0d", i));
      mute = 1'b0;
    end

    // Positive saturation: four voices at 2^23, all in phase 1
    for (int v = 0; v < 4; v++) cfg(3'(v), 19'd1000, 24'h800000, 2'b11);
    repeat (1005) @(negedge clk);
    run_txn(32'h7FFFFF00, 32'h7FFFFF00, 32'h7FFFFFFF, 32'h7FFFFFFF, "sat_pos");

    // Negative saturation: same voices restarted, all in phase 0
    for (int v = 0; v < 4; v++) cfg(3'(v), 19'd1000, 24'h800000, 2'b11);
    run_txn(32'h80000100, 32'h80000100, 32'h80000000, 32'h80000000, "sat_neg");

    // Out-of-range voice index must not disturb any voice
    for (int v = 0; v < 3; v++) cfg(3'(v), 19'd0, 24'd0, 2'b11);
    cfg(3'd3, 19'd1000, 24'd100, 2'b11);
    cfg(3'd7, 19'd1, 24'd5000, 2'b11);
    run_txn(32'd0, 32'd0, -32'sd100, -32'sd100, "voice7_ignored");

    // DAC stall in WRITE: no write for 10 cycles, output held, then one pulse
    cfg(3'd3, 19'd0, 24'd0, 2'b11);
    l_in = 32'd700; r_in = 32'd700; avail = 1'b1; allowed = 1'b1;
    @(negedge clk);
    check("stall_read", {31'd0, rd}, 32'd1);
    avail = 1'b0; allowed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (wr !== 1'b0 || l_out !== 32'd700 || r_out !== 32'd700) ok = 1'b0;
      @(negedge clk);
    end
    check("stall_hold", {31'd0, ok}, 32'd1);
    allowed = 1'b1;
    #1;
    check("stall_release_write", {31'd0, wr}, 32'd1);
    check("stall_left", l_out, 32'd700);
    @(negedge clk);
    check("stall_single_write", {31'd0, wr}, 32'd0);
    @(negedge clk);
    check("stall_idle_write", {31'd0, wr}, 32'd0);

    // Pan: voice 0 left only, phase 1
`ifdef STEREO_PAN_EN
    exp_r_pan = 32'd0;
`else
    exp_r_pan = 32'd50;
`endif
    cfg(3'd0, 19'd1000, 24'd50, 2'b10);
    repeat (1005) @(negedge clk);
    run_txn(32'd0, 32'd0, 32'd50, exp_r_pan, "pan");

    // Reset asserted while in MIX: sample dropped, no write pulse
    l_in = 32'd77; r_in = 32'd77; avail = 1'b1; allowed = 1'b1;
    @(negedge clk);
    avail = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_read",  {31'd0, rd}, 32'd0);
    check("midrst_write", {31'd0, wr}, 32'd0);
    check("midrst_left",  l_out, 32'd0);
    check("midrst_right", r_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (wr !== 1'b0 || rd !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("midrst_no_pulse", {31'd0, ok}, 32'd1);
    run_txn(32'd123, 32'd123, 32'd123, 32'd123, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
